// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    // Op encodings already own MD_DIV, so the state literals use an ST_ prefix.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply (LSB first) or
// restoring shift-subtract divide (quotient MSB first).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic           ge;

    always_comb begin
        sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        sh  = {hi_i, lo_i[WIDTH-1]};
        ge  = (sh >= {1'b0, b_i});
        if (is_div_i) begin
            // When ge holds the true difference is below b, so WIDTH bits suffice.
            hi_o = ge ? (sh[WIDTH-1:0] - b_i) : sh[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], ge};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional multiply early termination: define MULDIV_EARLY_OUT_EN.
module hilo_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_wr_en,
    input  logic             lo_wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hilo_read_req,
    output logic [WIDTH-1:0] hi_read,
    output logic [WIDTH-1:0] lo_read,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             is_div_q, is_div_d, done_q, done_d;

    muldiv_op_t         op_t;
    logic               sgn, a_neg, b_neg, div0;
    logic [WIDTH-1:0]   mag_a, mag_b, step_hi, step_lo, quo, rem;
    logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   pend_mask;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (state_q == ST_DIV),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        op_t  = muldiv_op_t'(op);
        sgn   = op_is_signed(op_t);
        // Divide-by-zero runs unsigned on the raw dividend: the restoring
        // sequence then leaves HI=operand_a and LO=all ones by itself.
        div0  = op[1] && (operand_b == '0);
        a_neg = sgn && !div0 && operand_a[WIDTH-1];
        b_neg = sgn && !div0 && operand_b[WIDTH-1];
        mag_a = a_neg ? -operand_a : operand_a;
        mag_b = b_neg ? -operand_b : operand_b;

        prod = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_EARLY_OUT_EN
        prod      = prod >> cnt_q;
        pend_mask = ~({WIDTH{1'b1}} << (cnt_q - 1'b1));
`endif
        if (neg_lo_q) prod = -prod;
        quo = neg_lo_q ? -acc_lo_q : acc_lo_q;
        rem = neg_hi_q ? -acc_hi_q : acc_hi_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_d      = b_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_wr_en) hi_d = wr_data;
                if (lo_wr_en) lo_d = wr_data;
                if (start) begin
                    is_div_d = op[1];
                    cnt_d    = CNT_W'(WIDTH);
                    acc_hi_d = '0;
                    if (op[1]) begin
                        acc_lo_d = mag_a;
                        b_d      = mag_b;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        state_d  = ST_DIV;
                    end else begin
                        acc_lo_d = mag_b;
                        b_d      = mag_a;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = 1'b0;
                        state_d  = ST_MUL;
`ifdef MULDIV_EARLY_OUT_EN
                        if (mag_b == '0) state_d = ST_FIX;
`endif
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                if (state_q == ST_MUL && (step_lo & pend_mask) == '0) state_d = ST_FIX;
`endif
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else if (clk_enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_q      <= b_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi_read = hi_q;
    assign lo_read = lo_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign stall   = busy & (start | hilo_read_req | hi_wr_en | lo_wr_en);

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed self-checking bench for hilo_muldiv_seq (default build).
module tb_hilo_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset, clk_enable, start, hi_wr_en, lo_wr_en, hilo_read_req;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, wr_data, hi_read, lo_read;
    logic        busy, done, stall;

    int pass_cnt = 0;
    int total    = 0;

    hilo_muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .hi_wr_en(hi_wr_en),
        .lo_wr_en(lo_wr_en), .wr_data(wr_data), .hilo_read_req(hilo_read_req),
        .hi_read(hi_read), .lo_read(lo_read), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle; returns just after edge 0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        tick();
        start = 1'b0;
    endtask

    // Counts edges until done is seen; 100 means it never came.
    task automatic wait_done(output int edges);
        logic found;
        found = 1'b0;
        edges = 100;
        for (int i = 1; i <= 100; i++) begin
            if (!found) begin
                tick();
                if (done === 1'b1) begin
                    found = 1'b1;
                    edges = i;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; clk_enable = 1'b1; start = 1'b0; op = 2'b00;
        operand_a = '0; operand_b = '0; hi_wr_en = 1'b0; lo_wr_en = 1'b0;
        wr_data = '0; hilo_read_req = 1'b0;
        tick(); tick();
        total++; if (hi_read !== 32'h0) $display("FAIL reset_hi got %h want 0", hi_read); else pass_cnt++;
        total++; if (lo_read !== 32'h0) $display("FAIL reset_lo got %h want 0", lo_read); else pass_cnt++;
        total++; if ({busy, done, stall} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, stall}); else pass_cnt++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_multu_max();
        int n;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++; if (busy !== 1'b1) $display("FAIL multu_busy got %b want 1", busy); else pass_cnt++;
        wait_done(n);
        total++; if (n !== 33) $display("FAIL multu_latency got %0d want 33", n); else pass_cnt++;
        total++; if (hi_read !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", hi_read); else pass_cnt++;
        total++; if (lo_read !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", lo_read); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL multu_busy_done got %b want 0", busy); else pass_cnt++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL multu_done_pulse got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_mult_neg();
        int n;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        total++; if (n !== 33) $display("FAIL mult_latency got %0d want 33", n); else pass_cnt++;
        total++; if ({hi_read, lo_read} !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mult_neg got %h want ffffffffffffffeb", {hi_read, lo_read}); else pass_cnt++;
    endtask

    task automatic test_div_cases();
        int n;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        total++; if (n !== 33) $display("FAIL div_latency got %0d want 33", n); else pass_cnt++;
        total++; if (lo_read !== 32'hFFFF_FFFD) $display("FAIL div_neg_q got %h want fffffffd", lo_read); else pass_cnt++;
        total++; if (hi_read !== 32'hFFFF_FFFF) $display("FAIL div_neg_r got %h want ffffffff", hi_read); else pass_cnt++;

        issue(2'b11, 32'h0000_1234, 32'h0);
        wait_done(n);
        total++; if (n !== 33) $display("FAIL divu0_latency got %0d want 33", n); else pass_cnt++;
        total++; if ({hi_read, lo_read} !== 64'h0000_1234_FFFF_FFFF) $display("FAIL divu0 got %h want 00001234ffffffff", {hi_read, lo_read}); else pass_cnt++;

        issue(2'b10, 32'hFFFF_FFFB, 32'h0);
        wait_done(n);
        total++; if ({hi_read, lo_read} !== 64'hFFFF_FFFB_FFFF_FFFF) $display("FAIL div0_signed got %h want fffffffbffffffff", {hi_read, lo_read}); else pass_cnt++;

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        total++; if ({hi_read, lo_read} !== 64'h0000_0000_8000_0000) $display("FAIL div_ovf got %h want 0000000080000000", {hi_read, lo_read}); else pass_cnt++;

        issue(2'b11, 32'd1000, 32'd7);
        wait_done(n);
        total++; if ({hi_read, lo_read} !== {32'd6, 32'd142}) $display("FAIL divu_plain got %h want %h", {hi_read, lo_read}, {32'd6, 32'd142}); else pass_cnt++;
    endtask

    task automatic test_mt_idle();
        int n;
        lo_wr_en = 1'b1; wr_data = 32'h0000_0011;
        tick();
        lo_wr_en = 1'b0;
        total++; if (lo_read !== 32'h11) $display("FAIL mtlo_idle got %h want 00000011", lo_read); else pass_cnt++;
        hi_wr_en = 1'b1; wr_data = 32'h0000_0022;
        issue(2'b01, 32'd2, 32'd2);
        hi_wr_en = 1'b0;
        total++; if (hi_read !== 32'h22) $display("FAIL mthi_with_start got %h want 00000022", hi_read); else pass_cnt++;
        wait_done(n);
        total++; if ({hi_read, lo_read} !== {32'd0, 32'd4}) $display("FAIL mt_overwritten got %h want %h", {hi_read, lo_read}, {32'd0, 32'd4}); else pass_cnt++;
    endtask

    task automatic test_stall();
        int   n;
        logic bad;
        issue(2'b00, 32'd6, 32'd7);
        tick();
        hilo_read_req = 1'b1; hi_wr_en = 1'b1; wr_data = 32'h0000_A5A5;
        #1;
        bad = (stall !== 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (done !== 1'b1 && stall !== 1'b1) bad = 1'b1;
        end
        total++; if (bad || n >= 100) $display("FAIL stall_busy got bad=%b n=%0d want bad=0", bad, n); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL stall_done got %b want 0", stall); else pass_cnt++;
        total++; if ({hi_read, lo_read} !== {32'd0, 32'd42}) $display("FAIL stall_result got %h want %h", {hi_read, lo_read}, {32'd0, 32'd42}); else pass_cnt++;
        tick();
        hilo_read_req = 1'b0; hi_wr_en = 1'b0;
        total++; if ({hi_read, lo_read} !== {32'h0000_A5A5, 32'd42}) $display("FAIL mthi_after_done got %h want %h", {hi_read, lo_read}, {32'h0000_A5A5, 32'd42}); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        issue(2'b10, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) tick();
        #2 reset = 1'b0;
        #1;
        total++; if ({busy, done} !== 2'b00) $display("FAIL areset_flags got %b want 00", {busy, done}); else pass_cnt++;
        total++; if ({hi_read, lo_read} !== 64'h0) $display("FAIL areset_hilo got %h want 0", {hi_read, lo_read}); else pass_cnt++;
        tick();
        reset = 1'b1;
        tick(); tick();
        total++; if ({busy, done, hi_read, lo_read} !== 66'h0) $display("FAIL areset_no_result got %h want 0", {busy, done, hi_read, lo_read}); else pass_cnt++;
    endtask

    task automatic test_clk_enable();
        int n;
        issue(2'b01, 32'd1000, 32'd3000);
        for (int i = 0; i < 10; i++) tick();
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if ({busy, done} !== 2'b10) $display("FAIL cke_frozen got %b want 10", {busy, done}); else pass_cnt++;
        clk_enable = 1'b1;
        wait_done(n);
        total++; if (n !== 23) $display("FAIL cke_latency got %0d want 23", n); else pass_cnt++;
        total++; if ({hi_read, lo_read} !== {32'd0, 32'h002D_C6C0}) $display("FAIL cke_result got %h want %h", {hi_read, lo_read}, {32'd0, 32'h002D_C6C0}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        issue(2'b01, 32'd2, 32'd3);
        wait_done(n);
        issue(2'b11, 32'd100, 32'd7);
        total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept got %b want 10", {busy, done}); else pass_cnt++;
        total++; if (lo_read !== 32'd6) $display("FAIL b2b_first got %h want 00000006", lo_read); else pass_cnt++;
        wait_done(n);
        total++; if (n !== 33) $display("FAIL b2b_latency got %0d want 33", n); else pass_cnt++;
        total++; if ({hi_read, lo_read} !== {32'd2, 32'd14}) $display("FAIL b2b_second got %h want %h", {hi_read, lo_read}, {32'd2, 32'd14}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_neg();
        test_div_cases();
        test_mt_idle();
        test_stall();
        test_async_reset();
        test_clk_enable();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
